fb_draw_sequencer: RTL and testbench

//  Parametrised N-buffer framebuffer write sequencer between polygonRaster's coordinate stream and output_screen.
//  Per frame: kicks the rasteriser and clears the back buffer one pixel per cycle.

---
 rtl/fb_pkg.sv | 25 ++
 rtl/fb_addr_gen.sv | 81 ++++++++
 rtl/fb_draw_sequencer.sv | 151 +++++++++++++++
 tb/tb_fb_draw_sequencer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared types for the framebuffer draw sequencer: FSM states, the coordinate
// carrier and the buffer-rotation helper.
package fb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    KICK,
    CLEAR,
    DRAIN,
    PRESENT
  } fb_state_e;

  // Wide enough for any supported COORD_W; narrower ports are zero-extended.
  localparam int COORD_MAX_W = 16;

  typedef struct packed {
    logic [COORD_MAX_W-1:0] x;
    logic [COORD_MAX_W-1:0] y;
  } pixel_coord_t;

  function automatic int next_buf(input int idx, input int num);
    return (idx + 1 >= num) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/fb_addr_gen.sv
// Registered pixel-write stage: either a clear write or a coordinate converted
// to a linear address with an in-range test; out-of-range coords raise clip_o.
module fb_addr_gen
  import fb_pkg::*;
#(
  parameter int H_RES   = 320,
  parameter int V_RES   = 240,
  parameter int COLOR_W = 3,
  parameter int ADDR_W  = 17
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr_en_i,
  input  logic [ADDR_W-1:0]  clr_addr_i,
  input  logic [COLOR_W-1:0] clr_data_i,
  input  logic               coord_en_i,
  input  pixel_coord_t       coord_i,
  input  logic [COLOR_W-1:0] coord_data_i,
  output logic               we_o,
  output logic [ADDR_W-1:0]  addr_o,
  output logic [COLOR_W-1:0] data_o,
  output logic               clip_o,
  output logic               pend_o
);

  localparam int AW1 = ADDR_W + 1;
  localparam logic [COORD_MAX_W-1:0] X_LIM = COORD_MAX_W'(H_RES);
  localparam logic [COORD_MAX_W-1:0] Y_LIM = COORD_MAX_W'(V_RES);
  localparam logic [AW1-1:0]         PIX   = AW1'(H_RES * V_RES);

  logic               we_q, we_d;
  logic               clip_q, clip_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [COLOR_W-1:0] data_q, data_d;
  logic [AW1-1:0]     lin_addr;
  logic               in_range;

  always_comb begin
    // One spare bit so the sum cannot wrap before the range test.
    lin_addr = AW1'(coord_i.y) * AW1'(H_RES) + AW1'(coord_i.x);
    in_range = (coord_i.x < X_LIM) && (coord_i.y < Y_LIM) && (lin_addr < PIX);
    we_d     = 1'b0;
    clip_d   = 1'b0;
    addr_d   = addr_q;
    data_d   = data_q;
    if (clr_en_i) begin
      we_d   = 1'b1;
      addr_d = clr_addr_i;
      data_d = clr_data_i;
    end else if (coord_en_i) begin
      if (in_range) begin
        we_d   = 1'b1;
        addr_d = lin_addr[ADDR_W-1:0];
        data_d = coord_data_i;
      end else begin
        clip_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q   <= 1'b0;
      clip_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      we_q   <= we_d;
      clip_q <= clip_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  assign we_o   = we_q;
  assign clip_o = clip_q;
  assign addr_o = addr_q;
  assign data_o = data_q;
  assign pend_o = we_q | clip_q;

endmodule

// File: rtl/fb_draw_sequencer.sv
// N-buffer framebuffer write sequencer: kick rasteriser, clear back buffer,
// drain coordinates as pixel writes, then present and rotate buffers.
module fb_draw_sequencer
  import fb_pkg::*;
#(
  parameter int H_RES   = 320,
  parameter int V_RES   = 240,
  parameter int COLOR_W = 3,
  parameter int NUM_BUF = 2,
  parameter int COORD_W = 9,
  parameter int ADDR_W  = $clog2(H_RES * V_RES),
  parameter int BUF_W   = (NUM_BUF > 1) ? $clog2(NUM_BUF) : 1
) (
  input  logic               CLOCK_50,
  input  logic               reset_n,
  input  logic               run,
  input  logic [COLOR_W-1:0] clear_color,
  input  logic [COLOR_W-1:0] draw_color,
  output logic               raster_start,
  input  logic               raster_done,
  input  logic               coord_valid,
  input  logic [COORD_W-1:0] coord_x,
  input  logic [COORD_W-1:0] coord_y,
  output logic               coord_ready,
  input  logic               frame_switched,
  output logic [NUM_BUF-1:0] buf_wr_en,
  output logic [ADDR_W-1:0]  buf_addr,
  output logic [COLOR_W-1:0] buf_data,
  output logic [BUF_W-1:0]   draw_idx,
  output logic [BUF_W-1:0]   disp_idx,
  output logic               draw_done,
  output logic               busy,
  output logic [15:0]        clip_count,
  output fb_state_e          state_dbg
);

  // Coordinate handshake: a coordinate transfers on any rising edge where
  // coord_valid && coord_ready; coord_ready is high only in DRAIN.

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);

  fb_state_e          state_q, state_d;
  logic [ADDR_W-1:0]  clr_cnt_q, clr_cnt_d;
  logic               done_q, done_d;
  logic [BUF_W-1:0]   draw_idx_q, draw_idx_d;
  logic [BUF_W-1:0]   disp_idx_q, disp_idx_d;
  logic [15:0]        clip_q, clip_d;
  logic               clr_en;
  logic               accept;
  logic               st_we, st_clip, st_pend;
  pixel_coord_t       coord_s;

  assign accept    = (state_q == DRAIN) && coord_valid;
  assign coord_s.x = COORD_MAX_W'(coord_x);
  assign coord_s.y = COORD_MAX_W'(coord_y);

  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    done_d     = done_q;
    draw_idx_d = draw_idx_q;
    disp_idx_d = disp_idx_q;
    clip_d     = clip_q;
    clr_en     = 1'b0;
    // Done is sticky from CLEAR onwards so an early raster_done is not lost.
    if (raster_done && (state_q != IDLE) && (state_q != KICK)) done_d = 1'b1;
    if (st_clip && (clip_q != 16'hFFFF)) clip_d = clip_q + 16'd1;
    case (state_q)
      IDLE: begin
        if (run) state_d = KICK;
      end
      KICK: begin
        done_d    = 1'b0;
        clip_d    = '0;
        clr_cnt_d = '0;
        state_d   = CLEAR;
      end
      CLEAR: begin
        clr_en = 1'b1;
        if (clr_cnt_q == LAST_ADDR) begin
          clr_cnt_d = '0;
          state_d   = DRAIN;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      DRAIN: begin
        if (done_q && !coord_valid && !st_pend) state_d = PRESENT;
      end
      PRESENT: begin
        if (frame_switched) begin
          disp_idx_d = draw_idx_q;
          draw_idx_d = BUF_W'(next_buf(int'(draw_idx_q), NUM_BUF));
          state_d    = run ? KICK : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      clr_cnt_q  <= '0;
      done_q     <= 1'b0;
      draw_idx_q <= '0;
      disp_idx_q <= BUF_W'(NUM_BUF - 1);
      clip_q     <= '0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      done_q     <= done_d;
      draw_idx_q <= draw_idx_d;
      disp_idx_q <= disp_idx_d;
      clip_q     <= clip_d;
    end
  end

  fb_addr_gen #(
    .H_RES  (H_RES),
    .V_RES  (V_RES),
    .COLOR_W(COLOR_W),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk         (CLOCK_50),
    .rst_n       (reset_n),
    .clr_en_i    (clr_en),
    .clr_addr_i  (clr_cnt_q),
    .clr_data_i  (clear_color),
    .coord_en_i  (accept),
    .coord_i     (coord_s),
    .coord_data_i(draw_color),
    .we_o        (st_we),
    .addr_o      (buf_addr),
    .data_o      (buf_data),
    .clip_o      (st_clip),
    .pend_o      (st_pend)
  );

  // draw_idx only moves in PRESENT, when the write stage is empty.
  assign buf_wr_en    = st_we ? ({{(NUM_BUF-1){1'b0}}, 1'b1} << draw_idx_q) : '0;
  assign raster_start = (state_q == KICK);
  assign coord_ready  = (state_q == DRAIN);
  assign draw_done    = (state_q == PRESENT);
  assign busy         = (state_q != IDLE);
  assign draw_idx     = draw_idx_q;
  assign disp_idx     = disp_idx_q;
  assign clip_count   = clip_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_fb_draw_sequencer.sv
// Scoreboarded bench for fb_draw_sequencer on a small 20x12, 3-buffer setup.
`timescale 1ns/1ps
module tb_fb_draw_sequencer;
  import fb_pkg::*;

  localparam int H   = 20;
  localparam int V   = 12;
  localparam int CW  = 3;
  localparam int NB  = 3;
  localparam int XW  = 6;
  localparam int PIX = H * V;
  localparam int AW  = $clog2(PIX);
  localparam int BW  = 2;
  localparam int W   = NB + AW + CW;

  logic          CLOCK_50;
  logic          reset_n;
  logic          run;
  logic [CW-1:0] clear_color;
  logic [CW-1:0] draw_color;
  logic          raster_start;
  logic          raster_done;
  logic          coord_valid;
  logic [XW-1:0] coord_x;
  logic [XW-1:0] coord_y;
  logic          coord_ready;
  logic          frame_switched;
  logic [NB-1:0] buf_wr_en;
  logic [AW-1:0] buf_addr;
  logic [CW-1:0] buf_data;
  logic [BW-1:0] draw_idx;
  logic [BW-1:0] disp_idx;
  logic          draw_done;
  logic          busy;
  logic [15:0]   clip_count;
  fb_state_e     state_dbg;

  fb_draw_sequencer #(
    .H_RES(H), .V_RES(V), .COLOR_W(CW), .NUM_BUF(NB), .COORD_W(XW)
  ) dut (
    .CLOCK_50(CLOCK_50), .reset_n(reset_n), .run(run),
    .clear_color(clear_color), .draw_color(draw_color),
    .raster_start(raster_start), .raster_done(raster_done),
    .coord_valid(coord_valid), .coord_x(coord_x), .coord_y(coord_y),
    .coord_ready(coord_ready), .frame_switched(frame_switched),
    .buf_wr_en(buf_wr_en), .buf_addr(buf_addr), .buf_data(buf_data),
    .draw_idx(draw_idx), .disp_idx(disp_idx), .draw_done(draw_done),
    .busy(busy), .clip_count(clip_count), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [W-1:0] exp_q[$];
  int m_draw = 0;
  int m_disp = NB - 1;
  int m_clip = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [NB-1:0] oh(input int i);
    logic [NB-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  always @(negedge CLOCK_50) begin
    if (reset_n && (buf_wr_en != '0)) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_write: got %0h expected no write", {buf_wr_en, buf_addr, buf_data});
      end else begin
        check("write", {buf_wr_en, buf_addr, buf_data}, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_frame(input int mode);
    int n;
    n = 0;
    while (!raster_start && n < 20) begin
      @(negedge CLOCK_50);
      n++;
    end
    check("kick_seen", raster_start, 1);
    m_clip = 0;
    for (int a = 0; a < PIX; a++) exp_q.push_back({oh(m_draw), AW'(a), clear_color});
    if (mode == 2) begin
      coord_valid = 1'b1;
      coord_x     = XW'(3);
      coord_y     = XW'(4);
    end
    n = 0;
    while (!coord_ready && n < PIX + 20) begin
      @(negedge CLOCK_50);
      n++;
      raster_done = (mode == 2 && n == 3);
      if (n == 1) check("start_pulse_width", raster_start, 0);
    end
    raster_done = 1'b0;
    check("ready_after_clear", n, PIX + 1);
  endtask

  task automatic send(input int x, input int y, input bit done_with);
    int  n;
    bit  in_rng;
    coord_x     = XW'(x);
    coord_y     = XW'(y);
    coord_valid = 1'b1;
    raster_done = done_with;
    n = 0;
    while (!coord_ready && n < 20) begin
      @(negedge CLOCK_50);
      n++;
    end
    check("send_ready", coord_ready, 1);
    @(posedge CLOCK_50);
    in_rng = (x < H) && (y < V);
    if (in_rng) exp_q.push_back({oh(m_draw), AW'(y * H + x), draw_color});
    else m_clip++;
    @(negedge CLOCK_50);
    coord_valid = 1'b0;
    raster_done = 1'b0;
    check("wr_latency", buf_wr_en != '0, in_rng);
  endtask

  // mode 0: random coords, 1: directed coords, 2: valid held + done during clear
  task automatic do_frame(input int mode, input bit stop);
    int n, k;
    clear_color = CW'($urandom_range(0, 7));
    draw_color  = CW'($urandom_range(0, 7));
    if (mode == 1) draw_color = 3'd7;
    start_frame(mode);
    if (stop) run = 1'b0;
    if (mode == 2) begin
      send(3, 4, 1'b0);
    end else if (mode == 1) begin
      send(0, 0, 1'b0);
      send(H - 1, V - 1, 1'b0);
      send(10, 2, 1'b0);
      send(H, 0, 1'b0);
      send(0, V, 1'b1);
    end else begin
      frame_switched = 1'b1;
      @(negedge CLOCK_50);
      frame_switched = 1'b0;
      k = $urandom_range(3, 8);
      for (int i = 0; i < k; i++) begin
        repeat ($urandom_range(0, 2)) @(negedge CLOCK_50);
        send($urandom_range(0, H + 3), $urandom_range(0, V + 2), i == k - 1);
      end
    end
    n = 0;
    while (!draw_done && n < 20) begin
      @(negedge CLOCK_50);
      n++;
    end
    check("present_reached", draw_done, 1);
    check("queue_drained", exp_q.size(), 0);
    check("clip_count", clip_count, m_clip);
    check("draw_idx", draw_idx, m_draw);
    check("disp_idx", disp_idx, m_disp);
    coord_valid = 1'b1;
    coord_x     = '0;
    coord_y     = '0;
    repeat ($urandom_range(1, 3)) @(negedge CLOCK_50);
    check("present_ready", coord_ready, 0);
    check("present_hold", draw_done, 1);
    coord_valid    = 1'b0;
    frame_switched = 1'b1;
    @(negedge CLOCK_50);
    frame_switched = 1'b0;
    m_disp = m_draw;
    m_draw = (m_draw + 1) % NB;
    check("disp_after_switch", disp_idx, m_disp);
    check("draw_after_switch", draw_idx, m_draw);
    if (stop) begin
      check("idle_after_stop", busy, 0);
      repeat (3) @(negedge CLOCK_50);
      check("stays_idle", {busy, raster_start}, 0);
    end
  endtask

  task automatic reset_mid_drain();
    clear_color = CW'($urandom_range(0, 7));
    draw_color  = CW'($urandom_range(0, 7));
    run = 1'b1;
    start_frame(0);
    run = 1'b0;
    send(H + 1, 0, 1'b0);
    send(5, 5, 1'b0);
    check("pre_reset_clip", clip_count, m_clip);
    #2 reset_n = 1'b0;
    #1;
    check("rst_wr_en", buf_wr_en, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", coord_ready, 0);
    check("rst_state", state_dbg, IDLE);
    check("rst_draw_idx", draw_idx, 0);
    check("rst_disp_idx", disp_idx, NB - 1);
    check("rst_clip", clip_count, 0);
    exp_q.delete();
    m_draw = 0;
    m_disp = NB - 1;
    m_clip = 0;
    @(negedge CLOCK_50);
    reset_n = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset_n        = 1'b0;
    run            = 1'b0;
    clear_color    = '0;
    draw_color     = '0;
    raster_done    = 1'b0;
    coord_valid    = 1'b0;
    coord_x        = '0;
    coord_y        = '0;
    frame_switched = 1'b0;
    #22;
    check("init_state", state_dbg, IDLE);
    check("init_outputs", {raster_start, coord_ready, draw_done, busy, buf_wr_en}, 0);
    check("init_idx", {draw_idx, disp_idx}, {2'd0, 2'(NB - 1)});
    check("init_clip", clip_count, 0);
    @(negedge CLOCK_50);
    reset_n = 1'b1;
    @(negedge CLOCK_50);
    check("idle_without_run", busy, 0);

    run = 1'b1;
    do_frame(2, 1'b0);
    do_frame(1, 1'b0);
    do_frame(0, 1'b0);
    do_frame(0, 1'b0);
    do_frame(0, 1'b1);

    reset_mid_drain();
    run = 1'b1;
    do_frame(0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
